// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch redirect unit: default PC width,
// FSM state encoding and the flush counter width.
package fetch_redirect_unit_pkg;

    localparam int FRU_ADDR_W = 16;
    localparam int FRU_CNT_W  = 3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fru_state_e;

endpackage

// File: rtl/fetch_redirect_unit_pc_target_adder.sv
// Combinational PC adder shared by the branch-target and sequential paths.
// wrap_o is the carry (forward) or borrow (backward) out of the ADDR_W-bit result.
module pc_target_adder
    import fetch_redirect_unit_pkg::*;
#(
    parameter int ADDR_W = FRU_ADDR_W
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] offset_i,
    input  logic              dir_i,
    output logic [ADDR_W-1:0] target_o,
    output logic              wrap_o
);

    logic [ADDR_W:0] sum;

    // Extra top bit captures carry on add and borrow on subtract.
    always_comb begin
        if (dir_i) begin
            sum = {1'b0, base_i} + {1'b0, offset_i};
        end else begin
            sum = {1'b0, base_i} - {1'b0, offset_i};
        end
    end

    assign target_o = sum[ADDR_W-1:0];
    assign wrap_o   = sum[ADDR_W];

endmodule

// File: rtl/fetch_redirect_unit.sv
// PC owner at the fetch end: sequential advance, branch redirect, squash window
// of FLUSH_CYCLES cycles and a one-cycle flushBack handshake to the branch unit.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter int                ADDR_W       = FRU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              shouldBranch_i,
    input  logic              branchDirection_i,
    input  logic [ADDR_W-1:0] branchOffset_i,
    input  logic              fetchReady_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fetchValid_o,
    output logic              flushPipe_o,
    output logic              flushBack_o,
    output logic              wrap_o
);

    fru_state_e           state_q, state_d;
    logic [FRU_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 fv_q, fv_d;
    logic                 fp_q, fp_d;
    logic                 fb_q, fb_d;
    logic                 wrap_q, wrap_d;

    logic                 take_branch;
    logic [ADDR_W-1:0]    add_off;
    logic                 add_dir;
    logic [ADDR_W-1:0]    add_target;
    logic                 add_wrap;

    // One adder serves both paths: branch offset when redirecting, +1 otherwise.
    assign take_branch = (state_q == RUN) && shouldBranch_i;
    assign add_off     = take_branch ? branchOffset_i : ADDR_W'(1);
    assign add_dir     = take_branch ? branchDirection_i : 1'b1;

    pc_target_adder #(.ADDR_W(ADDR_W)) u_adder (
        .base_i   (pc_q),
        .offset_i (add_off),
        .dir_i    (add_dir),
        .target_o (add_target),
        .wrap_o   (add_wrap)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        fv_d    = fv_q;
        fp_d    = fp_q;
        fb_d    = 1'b0;
        wrap_d  = 1'b0;
        if (enable_i) begin
            case (state_q)
                RUN: begin
                    if (shouldBranch_i) begin
                        pc_d    = add_target;
                        wrap_d  = add_wrap;
                        fb_d    = 1'b1;
                        fp_d    = 1'b1;
                        fv_d    = 1'b0;
                        cnt_d   = FRU_CNT_W'(FLUSH_CYCLES - 1);
                        state_d = FLUSH;
                    end else begin
                        fv_d = 1'b1;
                        if (fv_q && fetchReady_i) begin
                            pc_d   = add_target;
                            wrap_d = add_wrap;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        fp_d    = 1'b0;
                        fv_d    = 1'b1;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            fv_q    <= 1'b0;
            fp_q    <= 1'b0;
            fb_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            fv_q    <= fv_d;
            fp_q    <= fp_d;
            fb_q    <= fb_d;
            wrap_q  <= wrap_d;
        end
    end

    assign pc_o         = pc_q;
    assign fetchValid_o = fv_q;
    assign flushPipe_o  = fp_q;
    assign flushBack_o  = fb_q;
    assign wrap_o       = wrap_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: integer-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_fetch_redirect_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        br;
    logic        dir;
    logic [15:0] off;
    logic        rdy;
    logic [15:0] pc;
    logic        fv, fp, fb, wr;

    int n_total = 0;
    int n_pass  = 0;

    fetch_redirect_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(FC)) dut (
        .clock_i           (clk),
        .reset_i           (rst_n),
        .enable_i          (en),
        .shouldBranch_i    (br),
        .branchDirection_i (dir),
        .branchOffset_i    (off),
        .fetchReady_i      (rdy),
        .pc_o              (pc),
        .fetchValid_o      (fv),
        .flushPipe_o       (fp),
        .flushBack_o       (fb),
        .wrap_o            (wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: PC as a plain integer, flush as "cycles of squash left".
    int m_pc;
    int m_left;
    int s;
    bit m_fv, m_fp, m_fb, m_wrap, m_init;

    initial m_init = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 0; m_fv = 0; m_fp = 0; m_fb = 0; m_wrap = 0; m_left = 0; m_init = 1;
        end else if (en) begin
            m_fb = 0;
            m_wrap = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_fp = 0;
                    m_fv = 1;
                end
            end else if (br) begin
                if (dir) begin
                    s = m_pc + int'(off);
                    m_wrap = (s > 65535);
                end else begin
                    s = m_pc - int'(off);
                    m_wrap = (s < 0);
                end
                m_pc = (s + 65536) % 65536;
                m_fb = 1; m_fp = 1; m_fv = 0; m_left = FC;
            end else begin
                if (m_fv && rdy) begin
                    m_wrap = (m_pc == 65535);
                    m_pc = (m_pc + 1) % 65536;
                end
                m_fv = 1;
            end
        end else begin
            m_fb = 0;
            m_wrap = 0;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("model_pc",    32'(pc), 32'(m_pc));
            check("model_valid", 32'(fv), 32'(m_fv));
            check("model_flush", 32'(fp), 32'(m_fp));
            check("model_back",  32'(fb), 32'(m_fb));
            check("model_wrap",  32'(wr), 32'(m_wrap));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_branch(input logic d, input logic [15:0] o);
        br = 1'b1; dir = d; off = o;
        cyc();
        br = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; br = 1'b0; dir = 1'b0; off = '0; rdy = 1'b0;

        // 1. reset
        repeat (3) cyc();
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_fv", 32'(fv), 32'h0);
        check("rst_fp", 32'(fp), 32'h0);
        check("rst_fb", 32'(fb), 32'h0);
        check("rst_wrap", 32'(wr), 32'h0);
        rst_n = 1'b1;
        cyc();
        check("rel_fv", 32'(fv), 32'h1);
        check("rel_pc", 32'(pc), 32'h0);

        // 2. sequential
        rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("seq_pc", 32'(pc), 32'(i));
            check("seq_wrap", 32'(wr), 32'h0);
        end
        rdy = 1'b0;

        // 3. forward branch from 0x0010
        do_branch(1'b1, 16'd12);
        check("pre_pc", 32'(pc), 32'h10);
        repeat (2) cyc();
        do_branch(1'b1, 16'h0005);
        check("fwd_pc", 32'(pc), 32'h15);
        check("fwd_fb1", 32'(fb), 32'h1);
        check("fwd_fp1", 32'(fp), 32'h1);
        check("fwd_fv1", 32'(fv), 32'h0);
        cyc();
        check("fwd_fb2", 32'(fb), 32'h0);
        check("fwd_fp2", 32'(fp), 32'h1);
        cyc();
        check("fwd_fp3", 32'(fp), 32'h0);
        check("fwd_fv3", 32'(fv), 32'h1);

        // 4. backward wrap from 0x0002, then ignored branch during FLUSH
        do_branch(1'b0, 16'h0013);
        check("pre2_pc", 32'(pc), 32'h2);
        repeat (2) cyc();
        do_branch(1'b0, 16'h0004);
        check("bwd_pc", 32'(pc), 32'hFFFE);
        check("bwd_wrap", 32'(wr), 32'h1);
        br = 1'b1; dir = 1'b1; off = 16'h0100;
        cyc();
        br = 1'b0;
        check("ign_pc", 32'(pc), 32'hFFFE);
        check("ign_wrap", 32'(wr), 32'h0);
        check("ign_fb", 32'(fb), 32'h0);
        cyc();
        check("ign_fv", 32'(fv), 32'h1);

        // forward wrap through the +1 path
        rdy = 1'b1;
        cyc();
        check("inc_pc1", 32'(pc), 32'hFFFF);
        check("inc_wrap1", 32'(wr), 32'h0);
        cyc();
        check("inc_pc2", 32'(pc), 32'h0);
        check("inc_wrap2", 32'(wr), 32'h1);

        // branch with fetchReady on the same edge, offset 0 self-redirect
        do_branch(1'b1, 16'h0000);
        check("self_pc", 32'(pc), 32'h0);
        check("self_fb", 32'(fb), 32'h1);
        check("self_fp", 32'(fp), 32'h1);
        repeat (2) cyc();
        check("self_pc2", 32'(pc), 32'h0);
        check("self_fv2", 32'(fv), 32'h1);
        rdy = 1'b0;

        // 5. stall mid-flush
        do_branch(1'b1, 16'h0003);
        cyc();
        check("stl_fp0", 32'(fp), 32'h1);
        en = 1'b0;
        repeat (3) cyc();
        check("stl_fp", 32'(fp), 32'h1);
        check("stl_pc", 32'(pc), 32'h3);
        check("stl_fv", 32'(fv), 32'h0);
        en = 1'b1;
        cyc();
        check("stl_done_fp", 32'(fp), 32'h0);
        check("stl_done_fv", 32'(fv), 32'h1);

        // 6. reset mid-flush, then branch on first edge after release
        do_branch(1'b1, 16'h0007);
        check("mid_pc", 32'(pc), 32'hA);
        rst_n = 1'b0;
        cyc();
        check("mrst_pc", 32'(pc), 32'h0);
        check("mrst_fp", 32'(fp), 32'h0);
        check("mrst_fv", 32'(fv), 32'h0);
        rst_n = 1'b1;
        cyc();
        check("mrst_fv2", 32'(fv), 32'h1);
        check("mrst_fp2", 32'(fp), 32'h0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        do_branch(1'b1, 16'h0009);
        check("first_pc", 32'(pc), 32'h9);
        check("first_fp", 32'(fp), 32'h1);
        check("first_fv", 32'(fv), 32'h0);
        repeat (2) cyc();
        check("first_fv2", 32'(fv), 32'h1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
